// File: rtl/gf22_sram_reader_pkg.sv
// Shared types and constants for the GF22 SRAM burst reader.
package gf22_sram_reader_pkg;

  localparam int unsigned SRAM_DW   = 64;
  localparam int unsigned DEPTH_MIN = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [SRAM_DW-1:0] data;
    logic               last;
  } fifo_entry_t;

endpackage

// File: rtl/gf22_sram_reader_fifo.sv
// Small synchronous FIFO with occupancy count; empty reads return zero.
module gf22_sram_reader_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is not reset; the zero-gated read port hides stale entries instead.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = (cnt != '0) ? mem[rd_ptr] : '0;
  assign count   = cnt;

endmodule

// File: rtl/gf22_sram64_burst_reader.sv
// Burst read initiator for the GF22 1W/1R SRAM wrapper read port, output on a valid/ready stream.
// Optional request bounds check enabled by defining GF22_SRAM_READER_BOUNDS_CHECK_EN.
module gf22_sram64_burst_reader
  import gf22_sram_reader_pkg::*;
#(
  parameter int unsigned ABITS = 13,
  parameter int unsigned DW    = SRAM_DW,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [ABITS:0]   req_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DW-1:0]    Q1,
  output logic             err
);

  localparam int unsigned FIFO_DEPTH = (DEPTH < DEPTH_MIN) ? DEPTH_MIN : DEPTH;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);

  state_t           state, state_nxt;
  logic [ABITS-1:0] addr_q;
  logic [ABITS-1:0] a1_q;
  logic [ABITS:0]   remaining_q;
  logic             inflight_q;
  logic             inflight_last_q;
  logic             ready_en_q;

  logic             handshake;
  logic             start;
  logic             out_of_range;
  logic             issue;
  logic             last_issue;
  logic             pop;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;
  fifo_entry_t      wr_entry;
  fifo_entry_t      rd_entry;

  assign req_ready  = ready_en_q && (state == IDLE);
  assign handshake  = req_valid && req_ready;
  assign start      = handshake && (req_len != '0) && !out_of_range;
  assign last_issue = (remaining_q == (ABITS+1)'(1));
  assign pop        = out_valid && out_ready;

  // Words already committed to the FIFO: stored plus the one returning from the SRAM, less this cycle's pop.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (occupancy < (CW+1)'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (last_issue) state_nxt = DRAIN;
        end
      end
      DRAIN: if (!inflight_q && (fifo_count == CW'(pop))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state           <= IDLE;
      addr_q          <= '0;
      a1_q            <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      ready_en_q      <= 1'b0;
    end else begin
      state           <= state_nxt;
      ready_en_q      <= 1'b1;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
      if (start) begin
        addr_q      <= req_addr;
        remaining_q <= req_len;
      end else if (issue) begin
        addr_q      <= addr_q + ABITS'(1);
        remaining_q <= remaining_q - (ABITS+1)'(1);
        a1_q        <= addr_q;
      end
    end
  end

  // A1 shows the live address while issuing and otherwise holds the last one issued.
  assign CE1 = issue;
  assign A1  = issue ? addr_q : a1_q;

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = SRAM_DW'(Q1);
    wr_entry.last = inflight_last_q;
  end

  gf22_sram_reader_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .push    (inflight_q),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .count   (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_data  = DW'(rd_entry.data);
  assign out_last  = rd_entry.last;

`ifdef GF22_SRAM_READER_BOUNDS_CHECK_EN
  localparam logic [ABITS+1:0] ADDR_SPAN = (ABITS+2)'(1) << ABITS;

  logic [ABITS+1:0] req_end;
  logic             err_q;

  assign req_end      = {2'b00, req_addr} + {1'b0, req_len};
  assign out_of_range = (req_end > ADDR_SPAN);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) err_q <= 1'b0;
    else       err_q <= handshake && out_of_range;
  end

  assign err = err_q;
`else
  assign out_of_range = 1'b0;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_gf22_sram64_burst_reader.sv
// Directed self-checking bench for gf22_sram64_burst_reader with a one-cycle-latency SRAM model.
module tb_gf22_sram64_burst_reader;

  localparam int ABITS = 13;
  localparam int DW    = 64;
  localparam int DEPTH = 2;

  logic             CLK = 1'b0;
  logic             RSTN = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [ABITS-1:0] req_addr = '0;
  logic [ABITS:0]   req_len = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             CE1;
  logic [ABITS-1:0] A1;
  logic [DW-1:0]    Q1;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;

  gf22_sram64_burst_reader #(
    .ABITS (ABITS),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .CE1       (CE1),
    .A1        (A1),
    .Q1        (Q1),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  // SRAM preloaded with word[i] = i; junk on Q1 whenever no read was issued.
  always @(posedge CLK) begin
    if (CE1) Q1 <= DW'(A1);
    else     Q1 <= 64'hDEAD_BEEF_0BAD_F00D;
  end

  task automatic send_req(input logic [ABITS-1:0] a, input logic [ABITS:0] l);
    @(negedge CLK);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL req_ready_at_request: got %b want 1", req_ready);
    end
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++;
    if ({req_ready, out_valid, out_last, CE1, err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got rdy/vld/last/ce/err=%b want 00000",
               {req_ready, out_valid, out_last, CE1, err});
    end
    n_cmp++;
    if ({out_data, A1} !== '0) begin
      n_bad++;
      $display("FAIL reset_data_addr: got data=%h A1=%h want 0", out_data, A1);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    logic             exp_ce;
    logic [ABITS-1:0] exp_a1;
    logic             exp_v;
    logic             exp_l;
    logic [DW-1:0]    exp_d;
    out_ready = 1'b1;
    send_req(13'h010, 14'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      #1;
      exp_ce = (c <= 4);
      exp_a1 = (c <= 4) ? 13'(16 + c - 1) : 13'h013;
      n_cmp++;
      if ({CE1, A1} !== {exp_ce, exp_a1}) begin
        n_bad++;
        $display("FAIL basic_read_c%0d: got CE1=%b A1=%h want CE1=%b A1=%h", c, CE1, A1, exp_ce, exp_a1);
      end
      exp_v = (c >= 3) && (c <= 6);
      exp_l = (c == 6);
      exp_d = DW'(16 + c - 3);
      n_cmp++;
      if (exp_v) begin
        if ({out_valid, out_last, out_data} !== {exp_v, exp_l, exp_d}) begin
          n_bad++;
          $display("FAIL basic_out_c%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                   c, out_valid, out_last, out_data, exp_l, exp_d);
        end
      end else if ({out_valid, out_last} !== 2'b00) begin
        n_bad++;
        $display("FAIL basic_out_c%0d: got v=%b l=%b want v=0 l=0", c, out_valid, out_last);
      end
      n_cmp++;
      if (req_ready !== (c >= 7)) begin
        n_bad++;
        $display("FAIL basic_ready_c%0d: got %b want %b", c, req_ready, (c >= 7));
      end
    end
  endtask

  task automatic test_backpressure();
    int            issued = 0;
    int            popped = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          done = 1'b0;
    send_req(13'h100, 14'd8);
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge CLK);
      out_ready = ((c % 4) == 1) || ((c % 4) == 0);
      #1;
      if (CE1) begin
        n_cmp++;
        if ((issued - popped - int'(out_valid && out_ready)) >= DEPTH) begin
          n_bad++;
          $display("FAIL bp_credit_c%0d: got outstanding=%0d want <%0d", c,
                   issued - popped - int'(out_valid && out_ready), DEPTH);
        end
        n_cmp++;
        if (A1 !== 13'(256 + issued)) begin
          n_bad++;
          $display("FAIL bp_addr_c%0d: got %h want %h", c, A1, 13'(256 + issued));
        end
        issued++;
      end
      if (stall_prev) begin
        n_cmp++;
        if ({out_valid, out_data, out_last} !== {1'b1, prev_data, prev_last}) begin
          n_bad++;
          $display("FAIL bp_stable_c%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   c, out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({out_data, out_last} !== {DW'(256 + popped), (popped == 7)}) begin
          n_bad++;
          $display("FAIL bp_word%0d: got d=%h l=%b want d=%h l=%b",
                   popped, out_data, out_last, DW'(256 + popped), (popped == 7));
        end
        popped++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      done       = req_ready;
    end
    n_cmp++;
    if (!done || issued != 8 || popped != 8) begin
      n_bad++;
      $display("FAIL bp_totals: got done=%b issued=%0d popped=%0d want 1/8/8", done, issued, popped);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_wrap();
`ifdef GF22_SRAM_READER_BOUNDS_CHECK_EN
    out_ready = 1'b1;
    send_req(13'h1FFE, 14'd4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      #1;
      n_cmp++;
      if ({err, CE1, out_valid, req_ready} !== {(c == 1), 3'b001}) begin
        n_bad++;
        $display("FAIL oob_c%0d: got err/ce/vld/rdy=%b want %b", c,
                 {err, CE1, out_valid, req_ready}, {(c == 1), 3'b001});
      end
    end
`else
    logic [ABITS-1:0] exp_a [4];
    exp_a[0] = 13'h1FFE;
    exp_a[1] = 13'h1FFF;
    exp_a[2] = 13'h0000;
    exp_a[3] = 13'h0001;
    out_ready = 1'b1;
    send_req(13'h1FFE, 14'd4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      #1;
      if (c <= 4) begin
        n_cmp++;
        if ({CE1, A1} !== {1'b1, exp_a[c-1]}) begin
          n_bad++;
          $display("FAIL wrap_addr_c%0d: got CE1=%b A1=%h want CE1=1 A1=%h", c, CE1, A1, exp_a[c-1]);
        end
      end
      if (c >= 3 && c <= 6) begin
        n_cmp++;
        if ({out_valid, out_last, out_data} !== {1'b1, (c == 6), DW'(exp_a[c-3])}) begin
          n_bad++;
          $display("FAIL wrap_out_c%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                   c, out_valid, out_last, out_data, (c == 6), DW'(exp_a[c-3]));
        end
      end
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap_err_c%0d: got %b want 0", c, err);
      end
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_ready: got %b want 1", req_ready);
    end
`endif
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    send_req(13'h040, 14'd0);
    @(negedge CLK);
    #1;
    n_cmp++;
    if ({CE1, out_valid, err, req_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL zero_len_idle: got ce/vld/err/rdy=%b want 0001", {CE1, out_valid, err, req_ready});
    end
    req_valid = 1'b1;
    req_addr  = 13'h055;
    req_len   = 14'd1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      #1;
      n_cmp++;
      if ({CE1, A1} !== {(c == 1), 13'h055}) begin
        n_bad++;
        $display("FAIL zero_next_read_c%0d: got CE1=%b A1=%h want CE1=%b A1=055", c, CE1, A1, (c == 1));
      end
      n_cmp++;
      if (c == 3 && {out_valid, out_last, out_data} !== {2'b11, DW'(16'h0055)}) begin
        n_bad++;
        $display("FAIL zero_next_out: got v=%b l=%b d=%h want v=1 l=1 d=55", out_valid, out_last, out_data);
      end else if (c != 3 && out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_next_idle_c%0d: got out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   popped = 0;
    int   got = 0;
    logic stopped = 1'b0;
    out_ready = 1'b1;
    send_req(13'h200, 14'd16);
    for (int c = 1; c <= 40 && !stopped; c++) begin
      @(negedge CLK);
      if (popped == 5) begin
        RSTN = 1'b0;
        #1;
        stopped = 1'b1;
        n_cmp++;
        if ({req_ready, out_valid, out_last, CE1, err} !== 5'b0 || {out_data, A1} !== '0) begin
          n_bad++;
          $display("FAIL midreset_outputs: got rdy/vld/last/ce/err=%b d=%h A1=%h want all 0",
                   {req_ready, out_valid, out_last, CE1, err}, out_data, A1);
        end
      end else begin
        #1;
        if (out_valid && out_ready) begin
          n_cmp++;
          if (out_data !== DW'(512 + popped)) begin
            n_bad++;
            $display("FAIL midreset_word%0d: got %h want %h", popped, out_data, DW'(512 + popped));
          end
          popped++;
        end
      end
    end
    n_cmp++;
    if (!stopped) begin
      n_bad++;
      $display("FAIL midreset_timeout: got %0d words want 5", popped);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    send_req(13'h300, 14'd2);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      #1;
      if (out_valid) begin
        n_cmp++;
        if ({out_data, out_last} !== {DW'(768 + got), (got == 1)}) begin
          n_bad++;
          $display("FAIL postreset_word%0d: got d=%h l=%b want d=%h l=%b",
                   got, out_data, out_last, DW'(768 + got), (got == 1));
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 2) begin
      n_bad++;
      $display("FAIL postreset_count: got %0d want 2", got);
    end
  endtask

  task automatic test_full();
    int   got = 0;
    int   idle_cycle = -1;
    out_ready = 1'b1;
    send_req(13'h000, 14'd8192);
    for (int c = 1; c <= 8400 && idle_cycle < 0; c++) begin
      @(negedge CLK);
      #1;
      if (out_valid) begin
        n_cmp++;
        if ({out_data, out_last} !== {DW'(got), (got == 8191)}) begin
          n_bad++;
          $display("FAIL full_word%0d: got d=%h l=%b want d=%h l=%b",
                   got, out_data, out_last, DW'(got), (got == 8191));
        end
        got++;
      end
      if (req_ready) idle_cycle = c;
    end
    n_cmp++;
    if (idle_cycle != 8195) begin
      n_bad++;
      $display("FAIL full_duration: got %0d cycles want 8195", idle_cycle);
    end
    n_cmp++;
    if (got != 8192) begin
      n_bad++;
      $display("FAIL full_count: got %0d words want 8192", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
